// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline: passes EX results through or runs one load/store
// on the valid/ready data bus, aligning and extending load data into the MEM/WB register.
module mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic                  i_mem_rd,
   input  logic                  i_mem_wr,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_result,
   output logic                  o_stall,
   output logic                  o_req_valid,
   input  logic                  i_req_ready,
   output logic                  o_req_we,
   output logic [ADDR_WIDTH-1:0] o_req_addr,
   output logic [DATA_WIDTH-1:0] o_req_wdata,
   output logic [3:0]            o_req_be,
   input  logic                  i_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_rsp_rdata,
   output logic                  o_misalign,
   output logic                  o_wb_valid,
   output logic [DATA_WIDTH-1:0] o_dmemu_dout,
   output logic                  o_dbg_state
);

   // Bus handshake: a request transfers on a cycle where o_req_valid and i_req_ready
   // are both high; the request fields stay stable while o_req_valid waits for ready.
   typedef enum logic {IDLE, WAIT_RSP} state_t;

   state_t          state;
   logic [1:0]      cap_off;
   logic [2:0]      cap_funct3;
   logic            is_mem;
   logic            misalign_c;
   logic            req_c;
   logic [3:0]      be_c;
   logic [DATA_WIDTH-1:0] wdata_c;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] load_ext;

   assign is_mem     = i_valid & (i_mem_rd | i_mem_wr);
   assign misalign_c = is_mem & (((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                                 ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00)));
   assign req_c      = ~i_rst & (state == IDLE) & is_mem & ~misalign_c;

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << i_addr[1:0];
            wdata_c = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            be_c    = 4'b0011 << i_addr[1:0];
            wdata_c = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign o_req_valid = req_c;
   assign o_req_we    = req_c & i_mem_wr;
   assign o_req_addr  = req_c ? {i_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign o_req_wdata = req_c ? wdata_c : '0;
   assign o_req_be    = req_c ? be_c : 4'b0000;

   // A store completes on acceptance, so only an unaccepted request or a load holds the pipe.
   always_comb begin
      o_stall = 1'b0;
      if (!i_rst) begin
         if (state == IDLE) o_stall = req_c & ~(i_req_ready & i_mem_wr);
         else               o_stall = ~i_rsp_valid;
      end
   end

   always_comb begin
      shifted  = i_rsp_rdata >> {cap_off, 3'b000};
      load_ext = shifted;
      case (cap_funct3)
         3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         o_wb_valid   <= 1'b0;
         o_dmemu_dout <= '0;
         o_misalign   <= 1'b0;
         cap_off      <= 2'b00;
         cap_funct3   <= 3'b000;
      end else begin
         o_wb_valid <= 1'b0;
         o_misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (i_valid && !is_mem) begin
                  o_wb_valid   <= 1'b1;
                  o_dmemu_dout <= i_result;
               end else if (misalign_c) begin
                  o_misalign <= 1'b1;
               end else if (req_c && i_req_ready) begin
                  if (i_mem_wr) begin
                     o_wb_valid   <= 1'b1;
                     o_dmemu_dout <= '0;
                  end else begin
                     state      <= WAIT_RSP;
                     cap_off    <= i_addr[1:0];
                     cap_funct3 <= i_funct3;
                  end
               end
            end
            WAIT_RSP: begin
               if (i_rsp_valid) begin
                  state        <= IDLE;
                  o_wb_valid   <= 1'b1;
                  o_dmemu_dout <= load_ext;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_dbg_state = (state == WAIT_RSP);

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 5-stage RV32 core, directly upstream of the writeback unit. It takes the EX-stage result and either passes it through or performs a load/store over a valid/ready data-memory bus. Load data is aligned and sign/zero-extended here. The block produces the registered MEM/WB data word (o_dmemu_dout) that writeback selects for ALU, DMEM, CSR and MUL writes. It stalls the upstream pipeline while a memory access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath and bus data width (only 32 supported)
ADDR_WIDTH, 32, data-memory byte address width

Ports:
i_clk  input  1  core clock
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  instruction present in MEM this cycle
i_mem_rd  input  1  instruction is a load
i_mem_wr  input  1  instruction is a store (never both with i_mem_rd)
i_funct3  input  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_addr  input  ADDR_WIDTH  effective byte address from ALU
i_wdata  input  DATA_WIDTH  store data (rs2)
i_result  input  DATA_WIDTH  non-memory result (ALU/CSR/MUL, already selected)
o_stall  output  1  hold upstream stages; inputs held stable while high
o_req_valid  output  1  bus request valid
i_req_ready  input  1  bus accepts request
o_req_we  output  1  1 store, 0 load
o_req_addr  output  ADDR_WIDTH  word-aligned address (i_addr with [1:0]=0)
o_req_wdata  output  DATA_WIDTH  store data replicated to byte lanes
o_req_be  output  4  byte enables
i_rsp_valid  input  1  load response valid
i_rsp_rdata  input  DATA_WIDTH  raw load word
o_misalign  output  1  one-cycle pulse: misaligned access, request suppressed
o_wb_valid  output  1  registered: o_dmemu_dout valid for WB
o_dmemu_dout  output  DATA_WIDTH  registered data to writeback

Behaviour:
- Reset values: state=IDLE; o_wb_valid, o_dmemu_dout, o_misalign = 0. Request outputs are combinational and 0 in reset.
- States: IDLE, WAIT_RSP.
- IDLE with i_valid and no memory op: next cycle o_wb_valid=1, o_dmemu_dout=i_result. o_stall=0.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0. Then no request, o_misalign=1 the next cycle, o_wb_valid=0, no stall.
- IDLE with an aligned memory op: o_req_valid=1 combinationally that cycle. o_stall = ~(i_req_ready & i_mem_wr).
  - Store accepted (ready=1): done. Next cycle o_wb_valid=1, o_dmemu_dout=0; writeback ignores it.
  - Load accepted: go to WAIT_RSP.
  - Not accepted: stay in IDLE, request held.
- Byte enables: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111. Loads drive the same be pattern.
- Store data replication: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
- WAIT_RSP: o_req_valid=0, o_stall=1 until i_rsp_valid.
  - On the i_rsp_valid cycle, o_stall=0 and the state returns to IDLE.
  - Next cycle o_wb_valid=1 and o_dmemu_dout = extracted lane (shift by addr[1:0]*8), sign-extended for B/H and zero-extended for BU/HU.
  - The load address offset and funct3 are captured at request acceptance.
- Load-to-writeback latency: 1 cycle after the response. Pass-through latency: 1 cycle.
- o_wb_valid=0 in any cycle not listed above, including stall cycles and bubbles (i_valid=0).
- i_rsp_valid in IDLE is ignored.
- Reset mid-operation: return to IDLE. A response still in flight is dropped, because it arrives in IDLE and is ignored.
- One outstanding request maximum.

Test Plan:
- Pass-through: i_valid=1, no mem op, i_result=0x1234_5678 -> next cycle o_wb_valid=1, o_dmemu_dout=0x1234_5678, o_stall never high.
- LB signed: addr=0x103, rsp rdata=0x80AA_BBCC returned 2 cycles after acceptance -> be=1000, req_addr=0x100, stall high until rsp, then dout=0xFFFF_FF80; same access as LBU -> 0x0000_0080.
- SH with backpressure: addr=0x202, wdata=0x0000_BEEF, i_req_ready low 3 cycles -> request held stable 3 cycles with stall=1, be=1100, req_wdata=0xBEEF_BEEF; accepted on 4th cycle with stall=0.
- Misaligned LW addr=0x301 -> no o_req_valid, o_misalign=1 for exactly one cycle, o_wb_valid=0.
- Reset in WAIT_RSP: assert i_rst one cycle, then i_rsp_valid=1 -> no o_wb_valid, state IDLE, o_stall=0.
- Back-to-back: LW 0x400 (rsp 0xDEAD_BEEF) followed immediately by pass-through 0x55 -> WB sees 0xDEAD_BEEF then 0x55 in consecutive valid cycles.
